// File: rtl/toast_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: width, funct3 codes, FSM states.
package toast_muldiv_seq_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/toast_muldiv_seq_dp.sv
// Datapath: shared accumulator/low/operand registers, XLEN+1 add/subtract step and sign fix-up.
module toast_muldiv_seq_dp
    import toast_muldiv_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            special_i,
    input  logic [XLEN-1:0] special_val_i,
    input  logic            step_i,
    input  logic            finish_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic [XLEN-1:0] result_o
);

    // acc: product high half / remainder; lo: multiplier->product low / dividend->quotient
    logic [XLEN-1:0]   acc_q, acc_d, lo_q, lo_d, opb_q, opb_d, result_q, result_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              sign1, sign2, neg_in;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     mul_sum, div_sh, div_trial;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_val, div_fix;

    always_comb begin
        sign1  = op1_i[XLEN-1] &
                 (op_i == OpMulh || op_i == OpMulhsu || op_i == OpDiv || op_i == OpRem);
        sign2  = op2_i[XLEN-1] & (op_i == OpMulh || op_i == OpDiv || op_i == OpRem);
        abs1   = sign1 ? -op1_i : op1_i;
        abs2   = sign2 ? -op2_i : op2_i;
        neg_in = (op_i[2] && op_i[1]) ? sign1 : (sign1 ^ sign2);

        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_sh    = {acc_q, lo_q[XLEN-1]};
        div_trial = div_sh - {1'b0, opb_q};

        acc_d = acc_q;
        lo_d  = lo_q;
        opb_d = opb_q;
        op_d  = op_q;
        neg_d = neg_q;
        if (load_i) begin
            // Special cases park the answer in both halves so the normal select picks it up
            acc_d = special_i ? special_val_i : '0;
            lo_d  = special_i ? special_val_i : abs1;
            opb_d = abs2;
            op_d  = op_i;
            neg_d = special_i ? 1'b0 : neg_in;
        end else if (step_i) begin
            if (op_q[2]) begin
                acc_d = div_trial[XLEN] ? div_sh[XLEN-1:0] : div_trial[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], ~div_trial[XLEN]};
            end else begin
                acc_d = mul_sum[XLEN:1];
                lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
            end
        end

        // Select from next-state values so the final iteration and capture share one edge
        prod     = {acc_d, lo_d};
        prod_fix = neg_d ? -prod : prod;
        div_val  = op_d[1] ? acc_d : lo_d;
        div_fix  = neg_d ? -div_val : div_val;
        if (op_d[2]) begin
            result_d = div_fix;
        end else if (op_d[1:0] == 2'b00) begin
            result_d = prod_fix[XLEN-1:0];
        end else begin
            result_d = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            opb_q <= opb_d;
            op_q  <= op_d;
            neg_q <= neg_d;
            if (finish_i) begin
                result_q <= result_d;
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/toast_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, iteration counter, special cases, handshake.
module toast_muldiv_seq
    import toast_muldiv_seq_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [4:0]       rd_lat_q, rd_addr_q;
    logic             start_ok, div_zero, div_ovf, special, last_iter, load, step, finish;
    logic [XLEN-1:0]  special_val;

    always_comb begin
        start_ok  = (state_q == StIdle) && start_i && !flush_i;
        div_zero  = op_i[2] && (op2_i == '0);
        div_ovf   = op_i[2] && !op_i[0] && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (op2_i == '1);
        special   = div_zero || div_ovf;
        if (div_zero) begin
            special_val = op_i[1] ? op1_i : '1;
        end else begin
            special_val = op_i[1] ? '0 : op1_i;
        end
        last_iter = (state_q == StCalc) && (cnt_q == CNT_W'(XLEN - 1));
        load      = start_ok;
        step      = (state_q == StCalc) && !flush_i;
        finish    = (start_ok && special) || (last_iter && !flush_i);
        busy_o    = start_ok || (state_q == StCalc);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            rd_lat_q  <= '0;
            rd_addr_q <= '0;
        end else if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        cnt_q    <= '0;
                        rd_lat_q <= rd_addr_i;
                        if (special) begin
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                            rd_addr_q <= rd_addr_i;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        rd_addr_q <= rd_lat_q;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done_o    = done_q;
    assign rd_addr_o = rd_addr_q;

    toast_muldiv_seq_dp u_dp (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .load_i        (load),
        .special_i     (special),
        .special_val_i (special_val),
        .step_i        (step),
        .finish_i      (finish),
        .op_i          (op_i),
        .op1_i         (op1_i),
        .op2_i         (op2_i),
        .result_o      (result_o)
    );

endmodule

// File: tb/tb_toast_muldiv_seq.sv
// Directed self-checking bench for toast_muldiv_seq with hand-computed RV32M results.
module tb_toast_muldiv_seq;

    logic        clk_i = 1'b0;
    logic        reset_i, flush_i, start_i;
    logic [2:0]  op_i;
    logic [31:0] op1_i, op2_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int tests = 0;
    int fails = 0;

    toast_muldiv_seq dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .flush_i   (flush_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .op1_i     (op1_i),
        .op2_i     (op2_i),
        .rd_addr_i (rd_addr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .rd_addr_o (rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at cycle 0 and watch for done_o with a bounded wait.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
        int cyc;
        int lat;
        int busy_cnt;
        @(negedge clk_i);
        op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        #1;
        busy_cnt = busy_o ? 1 : 0;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        rd_addr_i = 5'd0;
        cyc = 1;
        lat = -1;
        while (cyc <= 40 && lat < 0) begin
            @(negedge clk_i);
            if (done_o) begin
                lat = cyc;
                check({tag, " result"}, result_o, exp_res);
                check({tag, " rd_addr"}, 32'(rd_addr_o), 32'(rd));
                check({tag, " busy in done"}, 32'(busy_o), 32'd0);
            end else begin
                if (busy_o) busy_cnt++;
                @(posedge clk_i);
                cyc++;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
        @(negedge clk_i);
        check({tag, " done single"}, 32'(done_o), 32'd0);
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        check({tag, " no done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int dones;
        logic [4:0] rd_seen;
        reset_i = 1'b1; flush_i = 1'b0; start_i = 1'b0;
        op_i = 3'd0; op1_i = '0; op2_i = '0; rd_addr_i = '0;
        repeat (2) @(negedge clk_i);
        check("reset done", 32'(done_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset rd", 32'(rd_addr_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;

        run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd1, 32'd14, 33);
        run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 5'd2, 32'd2, 33);
        run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFF, 33);
        run_op("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 33);
        run_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1);
        run_op("REMU 5/0", 3'b111, 32'd5, 32'd0, 5'd7, 32'd5, 1);
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1);
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1);
        run_op("MUL -1*-1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'd1, 33);
        run_op("MULH -1*-1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0, 33);
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 33);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFF, 33);

        // Flush at cycle 10 of a DIVU; last result must hold.
        @(negedge clk_i);
        op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd14; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        expect_no_done("flush", 40);
        check("flush result hold", result_o, 32'hFFFF_FFFF);

        // Start and flush together: dropped.
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1;
        #1 check("start+flush busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #1 start_i = 1'b0; flush_i = 1'b0;
        check("start+flush idle", 32'(busy_o), 32'd0);
        expect_no_done("start+flush", 40);

        run_op("MUL 3*4", 3'b000, 32'd3, 32'd4, 5'd15, 32'd12, 33);

        // Asynchronous reset mid-CALC.
        @(negedge clk_i);
        op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd16; start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check("areset result", result_o, 32'd0);
        check("areset rd", 32'(rd_addr_o), 32'd0);
        check("areset busy", 32'(busy_o), 32'd0);
        check("areset done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        expect_no_done("areset", 40);

        // start_i held through CALC: one done_o, first rd_addr.
        @(negedge clk_i);
        op_i = 3'b101; op1_i = 32'd100; op2_i = 32'd7; rd_addr_i = 5'd17; start_i = 1'b1;
        @(posedge clk_i);
        #1 rd_addr_i = 5'd30;
        op1_i = 32'd50;
        dones = 0;
        rd_seen = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                dones++;
                rd_seen = rd_addr_o;
                check("held start result", result_o, 32'd14);
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        check("held start done count", 32'(dones), 32'd1);
        check("held start rd", 32'(rd_seen), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
